dsp_result_collector: RTL and testbench

//  Downstream stage of DSP_top. Tracks every start pulse issued to the DSP through
//  a latency-matched valid delay line and samples the DSP `out` bus when that

---
 rtl/dsp_result_collector.sv | 130 +++++++++++++
 tb/tb_dsp_result_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_result_collector.sv
// Result collector for DSP_top: tracks starts through a latency-matched
// valid delay line and buffers each retired result in a show-ahead FIFO.
module dsp_result_collector #(
    parameter int WIDTH            = 8,
    parameter int PIPE_STAGE_WIDTH = 2,
    parameter int BASE_LATENCY     = 1,
    parameter int DEPTH            = 8,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PIPE_STAGE_WIDTH-1:0]   pipe_stages,
    input  logic [2*WIDTH-1:0]            dsp_out,
    output logic [2*WIDTH-1:0]            res_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          collision,
    output logic [CNT_WIDTH-1:0]          drop_count,
    input  logic                          clear_flags
);

    localparam int MAX_LAT = BASE_LATENCY + PIPE_STAGE_WIDTH;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int DW      = 2 * WIDTH;

    logic [MAX_LAT:1]     vline_q, vline_d, vline_sh;
    logic [DW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, col_q;
    logic                 ovf_d, col_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    int                   lat;
    logic                 col_ev, ovf_ev;
    logic                 push, pop, full, accept;
    logic [1:0]           inc;
    logic [CNT_WIDTH-1:0] drop_base;
    logic [CNT_WIDTH:0]   drop_sum;

    // Delay line: shift toward slot 1, then mark slot L for a new start.
    always_comb begin
        lat = BASE_LATENCY;
        for (int i = 0; i < PIPE_STAGE_WIDTH; i++) begin
            lat = lat + int'(pipe_stages[i]);
        end
        vline_sh = {1'b0, vline_q[MAX_LAT:2]};
        vline_d  = vline_sh;
        col_ev   = 1'b0;
        for (int i = 1; i <= MAX_LAT; i++) begin
            if (start && i == lat) begin
                if (vline_sh[i]) begin
                    col_ev = 1'b1;
                end else begin
                    vline_d[i] = 1'b1;
                end
            end
        end
    end

    // FIFO control: a retiring slot pushes; a full FIFO only accepts with a pop.
    always_comb begin
        push   = vline_q[1];
        pop    = res_valid && res_ready;
        full   = (count_q == CW'(DEPTH));
        accept = push && (!full || pop);
        ovf_ev = push && full && !pop;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky flags and saturating drop counter; clear still admits same-cycle events.
    always_comb begin
        inc       = {1'b0, ovf_ev} + {1'b0, col_ev};
        drop_base = clear_flags ? '0 : drop_q;
        drop_sum  = {1'b0, drop_base} + {{(CNT_WIDTH-1){1'b0}}, inc};
        drop_d    = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        ovf_d     = (clear_flags ? 1'b0 : ovf_q) | ovf_ev;
        col_d     = (clear_flags ? 1'b0 : col_q) | col_ev;
    end

    // Control state update; reset discards in-flight starts and buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            vline_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            col_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            vline_q <= vline_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            col_q   <= col_d;
            drop_q  <= drop_d;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage: DSP result written bit-exact when its slot retires.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_q[wr_ptr_q] <= dsp_out;
        end
    end

    assign res_valid  = (count_q != '0);
    assign res_data   = res_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign busy       = |vline_q;
    assign overflow   = ovf_q;
    assign collision  = col_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench for dsp_result_collector: vector table for single-cycle
// behaviour plus hand-written sequences for overflow, collision, clear and reset.
module tb_dsp_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  pipe_stages;
    logic [15:0] dsp_out;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  fifo_count;
    logic        busy;
    logic        overflow;
    logic        collision;
    logic [7:0]  drop_count;
    logic        clear_flags;

    int errors = 0;
    int checks = 0;

    dsp_result_collector #(
        .WIDTH(8), .PIPE_STAGE_WIDTH(2), .BASE_LATENCY(1),
        .DEPTH(8), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pipe_stages(pipe_stages),
        .dsp_out(dsp_out), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .fifo_count(fifo_count), .busy(busy),
        .overflow(overflow), .collision(collision),
        .drop_count(drop_count), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  ps;
        logic [15:0] dout;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  ec;
        logic        eb;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start       = 1'b0;
        pipe_stages = 2'd0;
        dsp_out     = 16'h0;
        res_ready   = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, res_valid, 0);
        chk({tag, " data"}, res_data, 0);
        chk({tag, " count"}, fifo_count, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " ovf"}, overflow, 0);
        chk({tag, " col"}, collision, 0);
        chk({tag, " drop"}, drop_count, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 16'h1234, 1'b0, 1'b1, 16'h1234, 4'd1, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1};
        tbl[4]  = '{1'b1, 2'd3, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1};
        tbl[5]  = '{1'b1, 2'd3, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1};
        tbl[6]  = '{1'b1, 2'd3, 16'hA001, 1'b1, 1'b1, 16'hA001, 4'd1, 1'b1};
        tbl[7]  = '{1'b0, 2'd3, 16'hA002, 1'b1, 1'b1, 16'hA002, 4'd1, 1'b1};
        tbl[8]  = '{1'b0, 2'd3, 16'hA003, 1'b1, 1'b1, 16'hA003, 4'd1, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 16'hA004, 1'b1, 1'b1, 16'hA004, 4'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Latency 1 single result, then latency 3 back-to-back stream.
        for (int i = 0; i < 11; i++) begin
            start       = tbl[i].st;
            pipe_stages = tbl[i].ps;
            dsp_out     = tbl[i].dout;
            res_ready   = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d valid", i), res_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("vec%0d data", i), res_data, tbl[i].ed);
            chk($sformatf("vec%0d count", i), fifo_count, tbl[i].ec);
            chk($sformatf("vec%0d busy", i), busy, tbl[i].eb);
        end

        // Fill past capacity: 10 results, 2 dropped.
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            start   = (i < 10);
            dsp_out = 16'h0100 + 16'(i);
            tick();
        end
        idle();
        chk("fill count", fifo_count, 8);
        chk("fill ovf", overflow, 1);
        chk("fill drop", drop_count, 2);
        chk("fill col", collision, 0);
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d data", i), res_data, 16'h0101 + 16'(i));
            chk($sformatf("drain%0d valid", i), res_valid, 1);
            tick();
        end
        chk("drain end valid", res_valid, 0);
        chk("drain end count", fifo_count, 0);

        // Latency shrink 3 -> 2 collides with the earlier start.
        do_reset();
        start = 1'b1; pipe_stages = 2'd3;
        tick();
        pipe_stages = 2'd1;
        tick();
        chk("col flag", collision, 1);
        chk("col drop", drop_count, 1);
        start = 1'b0; dsp_out = 16'h1111;
        tick();
        dsp_out = 16'h4444;
        tick();
        dsp_out = 16'h5555;
        tick();
        tick();
        chk("col count", fifo_count, 1);
        chk("col data", res_data, 16'h4444);
        chk("col busy", busy, 0);
        chk("col ovf", overflow, 0);

        // Full FIFO with pop and retire on the same edge.
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            start   = 1'b1;
            dsp_out = 16'h0500 + 16'(i);
            tick();
        end
        chk("full count", fifo_count, 8);
        start = 1'b0; res_ready = 1'b1; dsp_out = 16'h05AA;
        tick();
        chk("pushpop count", fifo_count, 8);
        chk("pushpop ovf", overflow, 0);
        chk("pushpop drop", drop_count, 0);
        chk("pushpop head", res_data, 16'h0502);
        res_ready = 1'b0;
        start = 1'b1; pipe_stages = 2'd3;
        tick();
        pipe_stages = 2'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("flags ovf", overflow, 1);
        chk("flags col", collision, 1);
        chk("flags drop", drop_count, 2);
        chk("flags count", fifo_count, 8);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("clear ovf", overflow, 0);
        chk("clear col", collision, 0);
        chk("clear drop", drop_count, 0);
        start = 1'b1; pipe_stages = 2'd0;
        tick();
        start = 1'b0; clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("clear+ovf ovf", overflow, 1);
        chk("clear+ovf drop", drop_count, 1);
        chk("clear+ovf col", collision, 0);

        // Reset with 3 buffered and 2 in flight.
        do_reset();
        start = 1'b1; pipe_stages = 2'd0;
        for (int i = 0; i < 3; i++) begin
            dsp_out = 16'h0600 + 16'(i);
            tick();
        end
        pipe_stages = 2'd3;
        tick();
        tick();
        chk("pre-rst count", fifo_count, 3);
        chk("pre-rst busy", busy, 1);
        rst = 1'b1; res_ready = 1'b1; clear_flags = 1'b0;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) begin
            dsp_out = 16'h0700 + 16'(i);
            tick();
            chk($sformatf("post-rst%0d valid", i), res_valid, 0);
        end
        chk("post-rst count", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
